board_draw_sequencer: RTL and testbench
=======================================

Name: board_draw_sequencer

Overview:
Schedules all cell redraws on the 8x8 Othello board through the single 12x12 cell-sprite plotter.
- Accepts full-board and single-cell redraw requests.
- Reads cell state from the synchronous board RAM and converts row/col to screen coordinates.
- Issues one draw command to the plotter per cell, then waits a fixed interval before the next.
- Sits between game logic / board RAM and the plotter that feeds the VGA adapter.

Parameters:
CELL, 12, cell pitch in pixels (x and y)
X_ORIGIN, 32, screen x of column 0
Y_ORIGIN, 12, screen y of row 0
DRAW_CYCLES, 150, cycles held in WAIT after each plotter start (covers 4-cycle start-up plus 144 pixels, with margin)

Ports:
clock  in  1  system clock
resetn  in  1  reset, asynchronous, active-high
full_req  in  1  pulse: redraw all 64 cells
cell_req  in  1  pulse: redraw one cell; accepted only when req_ready=1
cell_row  in  3  row for cell_req
cell_col  in  3  column for cell_req
cursor_row  in  3  cursor row (feature only)
cursor_col  in  3  cursor column (feature only)
board_addr  out  6  board RAM read address, row*8+col
board_data  in  2  RAM data, 1-cycle latency: 0 empty, 1 black, 2 white, 3 treated as empty
plot_x  out  8  cell origin x to plotter
plot_y  out  7  cell origin y to plotter
plot_select  out  2  00 empty, 01 cursor marker, 10 black, 11 white
plot_enable  out  1  single-cycle plotter start pulse
req_ready  out  1  high in IDLE with no pending work
busy  out  1  high outside IDLE
done  out  1  single-cycle pulse when a request, including its queued work, completes

Behaviour:
- Reset values: all outputs 0 except req_ready=1. State IDLE, pending flags cleared, wait counter 0.
- States: IDLE -> FETCH -> LATCH -> KICK -> WAIT -> NEXT -> (FETCH | IDLE).
- FETCH: drive board_addr; held stable through KICK.
- LATCH: capture board_data; compute plot_x = X_ORIGIN + col*CELL (8-bit) and plot_y = Y_ORIGIN + row*CELL (7-bit); compute plot_select.
- KICK: plot_enable=1 for exactly one cycle. plot_x, plot_y and plot_select hold from LATCH until the next LATCH.
- WAIT: count DRAW_CYCLES cycles, then go to NEXT. Per-cell cost is 3 + DRAW_CYCLES cycles.
- NEXT, full pass: advance row-major, (0,0) to (7,7), col fastest. After (7,7), end the pass.
- NEXT, single cell: end the operation.
- End of operation: service the pending full pass if set, else any pending cursor cells (feature), else go to IDLE and pulse done.
- Select mapping: 1 -> 10; 2 -> 11; 0 or 3 -> 00 (or 01, see feature).
- Priority in IDLE: full_req over cell_req. If both arrive in the same cycle, cell_req is dropped.
- full_req while busy: sets full_pending; the full pass starts after the current operation. Multiple requests collapse into one.
- cell_req while busy is ignored (req_ready=0).
- Async reset mid-draw: return to IDLE immediately, plot_enable low, pending flags cleared.
- Coordinate arithmetic uses no wrap checks; defaults give max x=116, max y=96.

Optional Feature:
CURSOR_HIGHLIGHT_EN
- Defined:
  - An empty cell (data 0 or 3) at (cursor_row, cursor_col) draws with select 01.
  - When cursor_row/cursor_col differ from their registered copy, schedule redraws of the old cell then the new cell, and update the copy. Each is a 1-cell op with no intermediate done; done pulses once after the new cell.
  - A cursor change detected while busy is held as one pending pair. The oldest old-position is kept and the newest new-position is used.
  - A full pass, running or pending, absorbs the pending pair, which is cleared.
- Undefined: cursor inputs unused, select 01 never produced, no automatic redraws.

Test Plan:
- Reset, then full_req with RAM all 0 -> 64 plot_enable pulses 153 cycles apart; first at (32,12) sel 00, last at (116,96); done pulse; busy returns to 0.
- RAM[27]=1, RAM[36]=2; cell_req (3,3) then, after done, cell_req (4,4) -> (68,48) sel 10, then (80,60) sel 11; one done each.
- full_req and cell_req in the same IDLE cycle -> full pass only, cell request dropped; full_req mid-pass -> second full pass follows immediately, single done at the end.
- cell_req while busy -> ignored, no extra plot_enable; assert resetn during WAIT -> plot_enable/busy 0 and all outputs at reset values on the next clock.
- With CURSOR_HIGHLIGHT_EN, RAM empty: cursor moves (0,0)->(0,1) -> draw (32,12) sel 00, then (44,12) sel 01, one done.
- Without CURSOR_HIGHLIGHT_EN: cursor moves -> no plot_enable.

Source files
------------

// File: rtl/board_draw_sequencer.sv
// Serialises Othello cell redraws (full board, single cell, cursor moves) into 12x12 plotter commands.
// Optional cursor highlighting is compiled in with `define CURSOR_HIGHLIGHT_EN.
module board_draw_sequencer #(
  parameter int CELL        = 12,
  parameter int X_ORIGIN    = 32,
  parameter int Y_ORIGIN    = 12,
  parameter int DRAW_CYCLES = 150
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       full_req,
  input  logic       cell_req,
  input  logic [2:0] cell_row,
  input  logic [2:0] cell_col,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  output logic [5:0] board_addr,
  input  logic [1:0] board_data,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [1:0] plot_select,
  output logic       plot_enable,
  output logic       req_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_KICK, S_WAIT, S_NEXT} state_t;
  typedef enum logic [1:0] {OP_FULL, OP_CELL, OP_CUR_OLD, OP_CUR_NEW} op_t;

  // The interval is measured from the start pulse, so KICK itself is the first of DRAW_CYCLES.
  localparam int CW = (DRAW_CYCLES > 2) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(DRAW_CYCLES - 2);

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [2:0]    row_q, row_d, col_q, col_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          full_pend_q, full_pend_d;
  logic [7:0]    plot_x_q, plot_x_d;
  logic [6:0]    plot_y_q, plot_y_d;
  logic [1:0]    sel_q, sel_d;
  logic [5:0]    cur_reg_q, cur_reg_d, cur_old_q, cur_old_d, cur_new_q, cur_new_d;
  logic [5:0]    act_new_q, act_new_d;
  logic          cur_pend_q, cur_pend_d;
  logic          cur_moved, go_full, go_cur, go_cell;
  logic [1:0]    empty_sel;

`ifdef CURSOR_HIGHLIGHT_EN
  assign empty_sel = ({row_q, col_q} == cur_reg_q) ? 2'b01 : 2'b00;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_row, cursor_col};
  assign empty_sel     = 2'b00;
`endif

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q     <= S_IDLE;
      op_q        <= OP_CELL;
      row_q       <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      full_pend_q <= 1'b0;
      plot_x_q    <= '0;
      plot_y_q    <= '0;
      sel_q       <= '0;
      cur_reg_q   <= '0;
      cur_old_q   <= '0;
      cur_new_q   <= '0;
      act_new_q   <= '0;
      cur_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wait_q      <= wait_d;
      full_pend_q <= full_pend_d;
      plot_x_q    <= plot_x_d;
      plot_y_q    <= plot_y_d;
      sel_q       <= sel_d;
      cur_reg_q   <= cur_reg_d;
      cur_old_q   <= cur_old_d;
      cur_new_q   <= cur_new_d;
      act_new_q   <= act_new_d;
      cur_pend_q  <= cur_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    row_d       = row_q;
    col_d       = col_q;
    wait_d      = wait_q;
    full_pend_d = full_pend_q | (full_req & (state_q != S_IDLE));
    plot_x_d    = plot_x_q;
    plot_y_d    = plot_y_q;
    sel_d       = sel_q;
    cur_reg_d   = cur_reg_q;
    cur_old_d   = cur_old_q;
    cur_new_d   = cur_new_q;
    act_new_d   = act_new_q;
    cur_pend_d  = cur_pend_q;
    cur_moved   = 1'b0;
    go_full     = 1'b0;
    go_cur      = 1'b0;
    go_cell     = 1'b0;
    plot_enable = 1'b0;
    done        = 1'b0;

`ifdef CURSOR_HIGHLIGHT_EN
    // Repeated moves merge: the first old position survives, the latest new one wins.
    cur_moved = ({cursor_row, cursor_col} != cur_reg_q);
    if (cur_moved) begin
      cur_reg_d  = {cursor_row, cursor_col};
      cur_new_d  = {cursor_row, cursor_col};
      cur_pend_d = 1'b1;
      if (!cur_pend_q) cur_old_d = cur_reg_q;
    end
`endif

    unique case (state_q)
      S_IDLE: begin
        if (full_req)        go_full = 1'b1;
        else if (cur_pend_q) go_cur  = 1'b1;
        else if (cell_req)   go_cell = 1'b1;
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        plot_x_d = 8'(X_ORIGIN + CELL * int'(col_q));
        plot_y_d = 7'(Y_ORIGIN + CELL * int'(row_q));
        if (board_data == 2'd1)      sel_d = 2'b10;
        else if (board_data == 2'd2) sel_d = 2'b11;
        else                         sel_d = empty_sel;
        state_d = S_KICK;
      end
      S_KICK: begin
        plot_enable = 1'b1;
        wait_d      = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_NEXT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (op_q == OP_FULL && {row_q, col_q} != 6'h3f) begin
          {row_d, col_d} = {row_q, col_q} + 6'd1;
          state_d        = S_FETCH;
        end else if (op_q == OP_CUR_OLD) begin
          {row_d, col_d} = act_new_q;
          op_d           = OP_CUR_NEW;
          state_d        = S_FETCH;
        end else if (full_pend_q || full_req) begin
          go_full = 1'b1;
        end else if (cur_pend_q) begin
          go_cur = 1'b1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_full) begin
      op_d        = OP_FULL;
      row_d       = '0;
      col_d       = '0;
      full_pend_d = 1'b0;
      state_d     = S_FETCH;
    end
    if (go_cur) begin
      // A move seen in this same cycle starts a fresh pair behind the one being launched.
      op_d           = OP_CUR_OLD;
      {row_d, col_d} = cur_old_q;
      act_new_d      = cur_new_q;
      cur_pend_d     = cur_moved;
      if (cur_moved) cur_old_d = cur_reg_q;
      state_d        = S_FETCH;
    end
    if (go_cell) begin
      op_d    = OP_CELL;
      row_d   = cell_row;
      col_d   = cell_col;
      state_d = S_FETCH;
    end
    // A running or queued full pass repaints every cell, so the cursor pair is redundant.
    if (full_pend_d || (op_d == OP_FULL && state_d != S_IDLE)) cur_pend_d = 1'b0;
  end

  assign board_addr  = {row_q, col_q};
  assign plot_x      = plot_x_q;
  assign plot_y      = plot_y_q;
  assign plot_select = sel_q;
  assign busy        = (state_q != S_IDLE);
  assign req_ready   = (state_q == S_IDLE) && !full_pend_q && !cur_pend_q;

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Self-checking bench for board_draw_sequencer: expected plot commands come from the cell/coordinate rules.
module tb_board_draw_sequencer;

  localparam int GAP = 153;
`ifdef CURSOR_HIGHLIGHT_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       full_req = 1'b0, cell_req = 1'b0;
  logic [2:0] cell_row = '0, cell_col = '0, cursor_row = '0, cursor_col = '0;
  logic [5:0] board_addr;
  logic [1:0] board_data = '0;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [1:0] plot_select;
  logic       plot_enable, req_ready, busy, done;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  logic [1:0]  ram [64];
  logic [16:0] ev_q[$];
  int          ev_t[$];
  logic [16:0] exp_q[$];

  board_draw_sequencer dut (
    .clock(clock), .resetn(resetn), .full_req(full_req), .cell_req(cell_req),
    .cell_row(cell_row), .cell_col(cell_col), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .board_addr(board_addr), .board_data(board_data), .plot_x(plot_x), .plot_y(plot_y),
    .plot_select(plot_select), .plot_enable(plot_enable), .req_ready(req_ready),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    board_data <= ram[board_addr];
  end

  always @(negedge clock) begin
    if (plot_enable) begin
      ev_q.push_back({plot_x, plot_y, plot_select});
      ev_t.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  function automatic logic [16:0] model_evt(input int r, input int c, input int data,
                                            input int cr, input int cc);
    int x, y, s;
    x = 32 + c * 12;
    y = 12 + r * 12;
    if (data == 1)      s = 2;
    else if (data == 2) s = 3;
    else                s = (CURSOR_ON && r == cr && c == cc) ? 1 : 0;
    return {x[7:0], y[6:0], s[1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_all();
    ev_q.delete();
    ev_t.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic expect_full_pass();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp_q.push_back(model_evt(r, c, int'(ram[r*8+c]), int'(cursor_row), int'(cursor_col)));
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt != start), 32'd1);
  endtask

  task automatic wait_events(input int count, input int budget, input string tag);
    int n;
    n = 0;
    while (ev_q.size() < count && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(ev_q.size() >= count), 32'd1);
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      check($sformatf("%s_evt%0d", tag, i), 32'(ev_q[i]), 32'(exp_q[i]));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'(ev_t[i] - ev_t[i-1]), 32'(GAP));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot_enable"}, 32'(plot_enable), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_req_ready"},   32'(req_ready),   32'd1);
    check({tag, "_board_addr"},  32'(board_addr),  32'd0);
    check({tag, "_plot_xy_sel"}, 32'({plot_x, plot_y, plot_select}), 32'd0);
  endtask

  task automatic run_cell(input int r, input int c, input string tag);
    clear_all();
    exp_q.push_back(model_evt(r, c, int'(ram[r*8+c]), int'(cursor_row), int'(cursor_col)));
    cell_row = 3'(r);
    cell_col = 3'(c);
    cell_req = 1'b1;
    tick();
    cell_req = 1'b0;
    wait_done(GAP + 50, {tag, "_done"});
    verify(tag);
    repeat (5) tick();
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 2'd0;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check_reset_outputs("reset");

    // Full pass over an empty board
    clear_all();
    expect_full_pass();
    full_req = 1'b1;
    tick();
    full_req = 1'b0;
    wait_done(64 * GAP + 100, "A_done");
    verify("A");
    repeat (20) tick();
    check("A_done_once", 32'(done_cnt), 32'd1);
    check("A_busy_low", 32'(busy), 32'd0);
    check("A_ready", 32'(req_ready), 32'd1);

    // Single-cell requests: fixed pieces, then random cells with random contents
    ram[27] = 2'd1;
    ram[36] = 2'd2;
    run_cell(3, 3, "B33");
    run_cell(4, 4, "B44");
    for (int k = 0; k < 6; k++) begin
      int r, c;
      r = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      ram[r*8+c] = 2'($urandom_range(0, 3));
      run_cell(r, c, $sformatf("Brnd%0d", k));
    end

    // Simultaneous full+cell, then full_req and cell_req mid-pass
    for (int i = 0; i < 64; i++) ram[i] = 2'($urandom_range(0, 3));
    clear_all();
    expect_full_pass();
    expect_full_pass();
    cell_row = 3'($urandom_range(0, 7));
    cell_col = 3'($urandom_range(0, 7));
    full_req = 1'b1;
    cell_req = 1'b1;
    tick();
    full_req = 1'b0;
    cell_req = 1'b0;
    wait_events(10, 11 * GAP + 50, "C_progress");
    check("C_busy", 32'(busy), 32'd1);
    check("C_not_ready", 32'(req_ready), 32'd0);
    full_req = 1'b1;
    tick();
    full_req = 1'b0;
    repeat (7) tick();
    cell_row = 3'($urandom_range(0, 7));
    cell_col = 3'($urandom_range(0, 7));
    cell_req = 1'b1;
    tick();
    cell_req = 1'b0;
    wait_done(2 * 64 * GAP + 200, "C_done");
    verify("C");
    repeat (200) tick();
    check("C_no_extra", 32'(ev_q.size()), 32'd128);
    check("C_done_once", 32'(done_cnt), 32'd1);

    // Asynchronous reset while waiting on the plotter
    clear_all();
    cell_row = 3'd5;
    cell_col = 3'd2;
    cell_req = 1'b1;
    tick();
    cell_req = 1'b0;
    wait_events(1, GAP, "D_started");
    repeat (20) tick();
    check("D_in_wait", 32'(busy), 32'd1);
    resetn = 1'b1;
    #1;
    check_reset_outputs("D_async");
    tick();
    check_reset_outputs("D_next_clk");
    repeat (2) tick();
    resetn = 1'b0;
    repeat (300) tick();
    check("D_no_more_plots", 32'(ev_q.size()), 32'd1);
    check("D_no_done", 32'(done_cnt), 32'd0);

    // Cursor movement
    for (int i = 0; i < 64; i++) ram[i] = 2'd0;
    clear_all();
`ifdef CURSOR_HIGHLIGHT_EN
    exp_q.push_back(model_evt(0, 0, 0, 0, 1));
    exp_q.push_back(model_evt(0, 1, 0, 0, 1));
    cursor_col = 3'd1;
    wait_done(2 * GAP + 100, "E_done");
    verify("E");
    repeat (20) tick();
    check("E_done_once", 32'(done_cnt), 32'd1);
`else
    cursor_row = 3'($urandom_range(1, 7));
    cursor_col = 3'($urandom_range(1, 7));
    repeat (400) tick();
    check("E_no_plots", 32'(ev_q.size()), 32'd0);
    check("E_no_done", 32'(done_cnt), 32'd0);
    check("E_idle", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
